// File: rtl/if_stage.sv
// Instruction fetch stage: one-request-per-cycle fetch from a fixed one-cycle-latency
// instruction memory into an IF/ID register backed by a one-entry skid buffer.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_exc
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        outstanding;
  logic        buf_valid;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;

  logic        transfer;
  logic        resp;
  logic        out_free;
  logic [1:0]  occupancy;

  // NOTE: every always_comb output gets an unconditional assignment so no latch is inferred.
  always_comb begin
    transfer  = if_id_valid & id_ready;
    resp      = imem_rvalid & outstanding;
    out_free  = ~if_id_valid | transfer;
    occupancy = {1'b0, if_id_valid} + {1'b0, buf_valid} + {1'b0, outstanding}
              - {1'b0, transfer};
    // Only issue when the response is guaranteed a slot; gated by rst_n so nothing
    // is requested while reset is held.
    imem_req  = rst_n && (state == RUN) && !redirect_valid && (occupancy < 2'd2);
    imem_addr = pc;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the skid buffer payload is reset along with everything else; it is only two
  // words, and keeping it defined avoids X propagation when it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      buf_valid   <= 1'b0;
      buf_pc      <= '0;
      buf_instr   <= '0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
      if_id_exc   <= 1'b0;
    end else begin
      outstanding <= imem_req;
      if (imem_req) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
      end

      if (redirect_valid) begin
        // Redirect wins over any response, transfer or issue this cycle.
        buf_valid <= 1'b0;
        if (redirect_pc[1:0] == 2'b00) begin
          state       <= RUN;
          pc          <= redirect_pc;
          if_id_valid <= 1'b0;
        end else begin
          state       <= HALT;
          if_id_valid <= 1'b1;
          if_id_pc    <= redirect_pc;
          if_id_instr <= NOP_INSTR;
          if_id_exc   <= 1'b1;
        end
      end else if (out_free) begin
        if (buf_valid) begin
          if_id_valid <= 1'b1;
          if_id_pc    <= buf_pc;
          if_id_instr <= buf_instr;
          if_id_exc   <= 1'b0;
          buf_valid   <= resp;
          if (resp) begin
            buf_pc    <= req_pc;
            buf_instr <= imem_rdata;
          end
        end else if (resp) begin
          if_id_valid <= 1'b1;
          if_id_pc    <= req_pc;
          if_id_instr <= imem_rdata;
          if_id_exc   <= 1'b0;
        end else begin
          if_id_valid <= 1'b0;
        end
      end else if (resp) begin
        buf_valid <= 1'b1;
        buf_pc    <= req_pc;
        buf_instr <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a one-cycle memory that returns the address as data,
// with stall, redirect, misaligned-halt, wrap and mid-stall reset scenarios.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_exc;

  logic        mem_rv;
  logic [31:0] mem_rd;
  logic        inject;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_exc      (if_id_exc)
  );

  // Memory answers every request exactly one cycle later with data == address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rv <= 1'b0;
      mem_rd <= '0;
    end else begin
      mem_rv <= imem_req;
      mem_rd <= imem_req ? imem_addr : 32'h0;
    end
  end

  assign imem_rvalid = mem_rv | inject;
  assign imem_rdata  = inject ? 32'hDEAD_BEEF : mem_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_entry(input string tag, input logic [31:0] pc,
                              input logic [31:0] instr, input logic exc);
    check({tag, " valid"}, {31'h0, if_id_valid}, 32'h1);
    check({tag, " pc"},    if_id_pc, pc);
    check({tag, " instr"}, if_id_instr, instr);
    check({tag, " exc"},   {31'h0, if_id_exc}, {31'h0, exc});
  endtask

  task automatic expect_outputs_reset(input string tag);
    check({tag, " valid"}, {31'h0, if_id_valid}, 32'h0);
    check({tag, " pc"},    if_id_pc, 32'h0);
    check({tag, " instr"}, if_id_instr, 32'h0);
    check({tag, " exc"},   {31'h0, if_id_exc}, 32'h0);
    check({tag, " req"},   {31'h0, imem_req}, 32'h0);
    check({tag, " addr"},  imem_addr, 32'h0);
  endtask

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inject         = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1 expect_outputs_reset("reset");

    // Release: first request to RESET_PC in the first cycle
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first req", {31'h0, imem_req}, 32'h1);
    check("first addr", imem_addr, 32'h0);
    @(negedge clk);
    check("latency empty", {31'h0, if_id_valid}, 32'h0);

    // Streaming, one per cycle, instr == pc
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expect_entry($sformatf("stream%0d", k), 32'(4 * k), 32'(4 * k), 1'b0);
    end

    // Stall for 5 cycles with entry 12 shown and 16 in flight
    id_ready = 1'b0;
    #1 check("stall req", {31'h0, imem_req}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_entry($sformatf("hold%0d", i), 32'h0C, 32'h0C, 1'b0);
      check($sformatf("hold%0d req", i), {31'h0, imem_req}, 32'h0);
    end
    id_ready = 1'b1;
    #1;
    check("resume req", {31'h0, imem_req}, 32'h1);
    check("resume addr", imem_addr, 32'h14);
    for (int k = 4; k < 8; k++) begin
      @(negedge clk);
      expect_entry($sformatf("resume%0d", k), 32'(4 * k), 32'(4 * k), 1'b0);
    end

    // Redirect together with a transfer of 0x1C and the rvalid for 0x20
    check("pre-redirect rvalid", {31'h0, imem_rvalid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1 check("redirect req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    check("post-redirect valid", {31'h0, if_id_valid}, 32'h0);
    #1;
    check("redirect fetch req", {31'h0, imem_req}, 32'h1);
    check("redirect fetch addr", imem_addr, 32'h100);
    @(negedge clk);
    check("redirect latency", {31'h0, if_id_valid}, 32'h0);
    @(negedge clk);
    expect_entry("target0", 32'h100, 32'h100, 1'b0);
    @(negedge clk);
    expect_entry("target1", 32'h104, 32'h104, 1'b0);

    // Misaligned redirect -> exception entry and HALT
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    expect_entry("exc", 32'h102, 32'h13, 1'b1);
    #1 check("halt req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    expect_entry("exc held", 32'h102, 32'h13, 1'b1);
    check("halt req held", {31'h0, imem_req}, 32'h0);
    id_ready = 1'b1;
    @(negedge clk);
    check("halt drained valid", {31'h0, if_id_valid}, 32'h0);
    check("halt drained req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    check("halt idle valid", {31'h0, if_id_valid}, 32'h0);

    // Aligned redirect out of HALT
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("restart valid", {31'h0, if_id_valid}, 32'h0);
    #1;
    check("restart req", {31'h0, imem_req}, 32'h1);
    check("restart addr", imem_addr, 32'h200);
    @(negedge clk);
    @(negedge clk);
    expect_entry("restart0", 32'h200, 32'h200, 1'b0);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_entry("wrap0", 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b0);
    @(negedge clk);
    expect_entry("wrap1", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    @(negedge clk);
    expect_entry("wrap2", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    expect_entry("wrap3", 32'h4, 32'h4, 1'b0);

    // Stall with full buffer, then reset pulse
    id_ready = 1'b0;
    @(negedge clk);
    expect_entry("full hold", 32'h4, 32'h4, 1'b0);
    check("full req", {31'h0, imem_req}, 32'h0);
    rst_n = 1'b0;
    #1 expect_outputs_reset("mid reset");
    @(negedge clk);
    rst_n    = 1'b1;
    id_ready = 1'b1;
    inject   = 1'b1;
    #1;
    check("refetch req", {31'h0, imem_req}, 32'h1);
    check("refetch addr", imem_addr, 32'h0);
    @(negedge clk);
    inject = 1'b0;
    check("stray rvalid ignored", {31'h0, if_id_valid}, 32'h0);
    @(negedge clk);
    expect_entry("refetch0", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    expect_entry("refetch1", 32'h4, 32'h4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, instruction word emitted with exceptions.
REQ-003 SHALL have one clock and an asynchronous active-low reset, ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 imem_req  output  1  fetch request, one per cycle max.
REQ-007 imem_addr  output  32  word-aligned fetch address, valid when imem_req=1.
REQ-008 imem_rvalid  input  1  response for the request issued exactly one cycle earlier.
REQ-009 imem_rdata  input  32  instruction word, valid when imem_rvalid=1.
REQ-010 redirect_valid  input  1  branch/jump/trap redirect from EX.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 id_ready  input  1  decode accepts the IF/ID entry this cycle.
REQ-013 if_id_valid  output  1  IF/ID entry valid.
REQ-014 if_id_pc  output  32  PC of the entry.
REQ-015 if_id_instr  output  32  instruction of the entry.
REQ-016 if_id_exc  output  1  instruction-address-misaligned flag for the entry.

Function
REQ-017 SHALL implement states RUN and HALT; HALT means fetch suspended after a misaligned redirect.
REQ-018 SHALL hold fetch PC register pc; each issued request uses imem_addr=pc, then pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-019 SHALL keep an IF/ID output register plus a one-entry skid buffer; an entry transfers when if_id_valid=1 and id_ready=1.
REQ-020 SHALL issue imem_req only in RUN, with no redirect this cycle, and (occupied output + occupied buffer + outstanding request - transfer this cycle) < 2, so no response is ever dropped.
REQ-021 On imem_rvalid (not killed): output register loads if empty or transferring this cycle, else buffer loads; buffer drains into output on the next free output slot, keeping program order.
REQ-022 With id_ready=1 continuously and no redirect, SHALL sustain one instruction per cycle; latency request->if_id_valid is 2 cycles (request N, rvalid N+1, visible N+2).
REQ-023 While if_id_valid=1 and id_ready=0, if_id_pc/instr/exc SHALL remain stable.
REQ-024 redirect_valid with redirect_pc[1:0]=0: next cycle output and buffer cleared (if_id_valid=0), any outstanding response killed (its rvalid ignored), pc<=redirect_pc, state RUN; first request to redirect_pc issued the cycle after redirect.
REQ-025 redirect_valid with redirect_pc[1:0]!=0: clear and kill as REQ-024, then next cycle present if_id_valid=1, if_id_exc=1, if_id_pc=redirect_pc, if_id_instr=NOP_INSTR; state HALT; no imem_req in HALT.
REQ-026 In HALT the exception entry SHALL persist until transferred; afterwards if_id_valid=0 until an aligned redirect.
REQ-027 Redirect SHALL take priority over simultaneous imem_rvalid, id_ready and issue in the same cycle; the transfer that cycle still counts as accepted by decode.
REQ-028 A redirect in HALT SHALL follow REQ-024/REQ-025 unchanged.
REQ-029 imem_addr SHALL equal pc whenever imem_req=0 (no X on outputs).

Reset
REQ-030 While rst_n=0: state RUN, pc=RESET_PC, imem_req=0, if_id_valid=0, if_id_pc=0, if_id_instr=0, if_id_exc=0, buffer empty, no outstanding request.
REQ-031 Reset assertion mid-operation SHALL discard all entries and outstanding requests immediately; an imem_rvalid in the first cycle after release SHALL be ignored.
REQ-032 First imem_req (addr RESET_PC) SHALL occur in the first cycle after rst_n deasserts.

Verification
REQ-033 Reset release, id_ready=1, memory returns addr as data -> if_id_pc 0,4,8,... one per cycle from cycle 3, if_id_instr==if_id_pc.
REQ-034 id_ready=0 for 5 cycles mid-stream -> at most 2 entries held, imem_req low after, if_id_pc stable; on release pc sequence continues without gap or duplicate.
REQ-035 redirect_valid with redirect_pc=32'h0000_0100 while request outstanding -> stale rvalid ignored, next if_id_pc=32'h100 then 32'h104.
REQ-036 redirect_pc=32'h0000_0102 -> if_id_valid=1, if_id_exc=1, if_id_pc=32'h102, if_id_instr=32'h13, no imem_req until redirect to 32'h200 restarts fetch at 32'h200.
REQ-037 Redirect in same cycle as id_ready=1 transfer and imem_rvalid -> only redirect stream appears; transferred entry not re-presented.
REQ-038 rst_n pulsed low during stall with full buffer -> all outputs at REQ-030 values, refetch from RESET_PC.
